// File: rtl/bus_arbiter_3.sv
// -----------------------------------------------------------------------------
// bus_arbiter_3
//
// Purpose:
//   Round-robin arbiter for three bus masters, with a hold limit. A master
//   keeps the bus while it requests. If another master is also requesting, the
//   owner is preempted after MAX_HOLD consecutive grant cycles. When the owner
//   releases, the bus passes to the next requester on the same edge, so there
//   is no idle cycle between owners.
//
// Parameters:
//   MAX_HOLD  - maximum number of consecutive grant cycles for one owner while
//               another master is waiting. Legal values are 2..255.
//
// Ports:
//   clk        in   single clock; all state changes on its rising edge
//   reset_n    in   asynchronous, active-low reset
//   m0_req     in   bus request from master 0
//   m1_req     in   bus request from master 1
//   m2_req     in   bus request from master 2
//   m0_grant   out  bus grant to master 0 (registered, one-hot-or-zero)
//   m1_grant   out  bus grant to master 1
//   m2_grant   out  bus grant to master 2
//   m_sel      out  encoded owner: 0/1/2 = m0/m1/m2, 3 = no owner
//   busy       out  high while any grant is high
// -----------------------------------------------------------------------------
module bus_arbiter_3 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m2_req,
  output logic       m0_grant,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic [1:0] m_sel,
  output logic       busy
);

  localparam int unsigned N_MASTERS  = 3;
  localparam logic [7:0]  HOLD_LIMIT = 8'(MAX_HOLD - 1);

  // Each grant state's encoding is the owner index, and IDLE is encoded as 3.
  // With this encoding m_sel is simply the state register.
  typedef enum logic [1:0] {
    G0   = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2,
    IDLE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_last_owner;
  logic [1:0] w_last_owner_next;
  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_cnt_next;

  logic [N_MASTERS-1:0] w_req;
  logic [N_MASTERS-1:0] w_req_others;
  logic [N_MASTERS-1:0] w_grant;
  logic                 w_own_req;
  logic [2:0]           w_pick;
  logic                 w_winner_valid;
  logic [1:0]           w_winner;

  assign w_req = {m2_req, m1_req, m0_req};

  // Decode grants from the state register. The current owner's request is
  // masked out of the search vector, so that one search serves all three
  // cases: arbitration from IDLE, handoff, and preemption. In IDLE, no bit
  // matches the state, so nothing is masked.
  generate
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
      assign w_grant[gi]      = (r_state == state_t'(2'(gi)));
      assign w_req_others[gi] = w_req[gi] && !w_grant[gi];
    end
  endgenerate

  assign w_own_req = |(w_req & w_grant);

  // Round-robin search that starts one position after the last owner.
  // The function returns {valid, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                         input logic [1:0] last);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    idx    = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!result[2] && req[idx]) begin
        result = {1'b1, idx};
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return result;
  endfunction

  assign w_pick         = rr_pick(w_req_others, r_last_owner);
  assign w_winner_valid = w_pick[2];
  assign w_winner       = w_pick[1:0];

  // Next-state logic
  always_comb begin
    w_state_next      = r_state;
    w_last_owner_next = r_last_owner;
    w_hold_cnt_next   = r_hold_cnt;

    case (r_state)
      IDLE: begin
        if (w_winner_valid) begin
          w_state_next      = state_t'(w_winner);
          w_last_owner_next = w_winner;
          w_hold_cnt_next   = 8'd0;
        end
      end

      default: begin
        if (w_own_req) begin
          if (r_hold_cnt < HOLD_LIMIT) begin
            // The owner keeps the bus and its tenure counter advances.
            w_hold_cnt_next = r_hold_cnt + 8'd1;
          end else if (w_winner_valid) begin
            // The tenure limit is reached and another master is waiting:
            // preempt the owner.
            w_state_next      = state_t'(w_winner);
            w_last_owner_next = w_winner;
            w_hold_cnt_next   = 8'd0;
          end
          // With no competitor, the owner stays and the counter stays
          // saturated. That lets a late competitor preempt at once.
        end else if (w_winner_valid) begin
          // The owner has released the bus. Hand it over on the same edge.
          w_state_next      = state_t'(w_winner);
          w_last_owner_next = w_winner;
          w_hold_cnt_next   = 8'd0;
        end else begin
          w_state_next = IDLE;
        end
      end
    endcase
  end

  // State registers. Reset is asynchronous, so grants drop without a clock
  // edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_owner <= 2'd2;
      r_hold_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_next;
      r_last_owner <= w_last_owner_next;
      r_hold_cnt   <= w_hold_cnt_next;
    end
  end

  assign m0_grant = w_grant[0];
  assign m1_grant = w_grant[1];
  assign m2_grant = w_grant[2];
  assign m_sel    = r_state;
  assign busy     = |w_grant;

endmodule

// File: tb/tb_bus_arbiter_3.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_3
//
// Purpose:
//   Self-checking bench for bus_arbiter_3 with MAX_HOLD = 8.
//   - A vector table gives request patterns and the owner expected after
//     each rising edge.
//   - Hand-written sequences cover the multi-cycle behaviour: the rotation
//     under full contention, the saturated hold, and an asynchronous reset in
//     the middle of a grant.
//   - A negedge monitor checks the grant/m_sel/busy invariants every cycle.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_3;

  logic       clk;
  logic       reset_n;
  logic       m0_req, m1_req, m2_req;
  logic       m0_grant, m1_grant, m2_grant;
  logic [1:0] m_sel;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] req;   // {m2, m1, m0}
    logic [1:0] sel;   // expected owner after the next edge (3 = none)
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[18];

  bus_arbiter_3 #(.MAX_HOLD(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .m0_req   (m0_req),
    .m1_req   (m1_req),
    .m2_req   (m2_req),
    .m0_grant (m0_grant),
    .m1_grant (m1_grant),
    .m2_grant (m2_grant),
    .m_sel    (m_sel),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares the outputs with the expected owner, packed as {busy, grants, sel}.
  task automatic check_owner(input string name, input logic [1:0] exp_sel);
    logic [5:0] got;
    logic [5:0] exp;
    logic [2:0] exp_gnt;
    exp_gnt = (exp_sel == 2'd3) ? 3'b000 : (3'b001 << exp_sel);
    got     = {busy, m2_grant, m1_grant, m0_grant, m_sel};
    exp     = {(exp_sel != 2'd3), exp_gnt, exp_sel};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy/grant/sel=%b required %b", name, got, exp);
    end else begin
      $display("[TB] %s: req=%b sel=%0d ok", name, {m2_req, m1_req, m0_req}, m_sel);
    end
  endtask

  // Drives one request pattern and pushes the expected owner. Then waits for
  // the edge, pops the expectation and compares.
  task automatic step(input logic [2:0] req, input logic [1:0] exp_sel, input string name);
    exp_t e;
    {m2_req, m1_req, m0_req} = req;
    e.sel  = exp_sel;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_owner(e.name, e.sel);
  endtask

  task automatic reset_pulse();
    {m2_req, m1_req, m0_req} = 3'b000;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // Invariant monitor: one-hot-or-zero grants, m_sel coherent with the grants,
  // busy equal to the OR of the grants.
  always @(negedge clk) begin
    logic [1:0] sel_from_gnt;
    logic       ok;
    case ({m2_grant, m1_grant, m0_grant})
      3'b001:  sel_from_gnt = 2'd0;
      3'b010:  sel_from_gnt = 2'd1;
      3'b100:  sel_from_gnt = 2'd2;
      default: sel_from_gnt = 2'd3;
    endcase
    ok = $onehot0({m2_grant, m1_grant, m0_grant}) && (m_sel === sel_from_gnt) &&
         (busy === (m0_grant | m1_grant | m2_grant));
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL invariant @%0t: grants=%b m_sel=%0d busy=%b",
               $time, {m2_grant, m1_grant, m0_grant}, m_sel, busy);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table (bit order {m2, m1, m0}). The expected owner is derived
    // from the round-robin rule, and the pointer starts at 2.
    vecs[0]  = '{3'b000, 2'd3};  // idle stays idle
    vecs[1]  = '{3'b010, 2'd1};  // single request m1, one-cycle latency
    vecs[2]  = '{3'b010, 2'd1};
    vecs[3]  = '{3'b000, 2'd3};  // release -> IDLE on next edge
    vecs[4]  = '{3'b000, 2'd3};
    vecs[5]  = '{3'b001, 2'd0};  // m0 from IDLE
    vecs[6]  = '{3'b101, 2'd0};  // m2 waits, m0 keeps bus
    vecs[7]  = '{3'b100, 2'd2};  // m0 drops -> m2 same edge
    vecs[8]  = '{3'b000, 2'd3};
    vecs[9]  = '{3'b111, 2'd0};  // last=2 -> m0 first
    vecs[10] = '{3'b110, 2'd1};  // m0 drops -> m1
    vecs[11] = '{3'b101, 2'd2};  // m1 drops -> m2
    vecs[12] = '{3'b011, 2'd0};  // m2 drops -> wraps to m0
    vecs[13] = '{3'b000, 2'd3};
    vecs[14] = '{3'b010, 2'd1};  // m1 request
    vecs[15] = '{3'b000, 2'd3};
    vecs[16] = '{3'b010, 2'd1};  // re-request treated fresh
    vecs[17] = '{3'b000, 2'd3};

    reset_n = 1'b0;
    {m2_req, m1_req, m0_req} = 3'b111;  // ignored while in reset
    @(posedge clk);
    @(posedge clk);
    #3;
    check_owner("reset_state", 2'd3);
    @(negedge clk);
    {m2_req, m1_req, m0_req} = 3'b000;
    #2;
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].req, vecs[i].sel, $sformatf("vec%0d", i));
    end

    // Full contention from a fresh reset: m0, m1, m2, m0 with 8 cycles each.
    reset_pulse();
    for (int i = 0; i < 32; i++) begin
      step(3'b111, 2'((i / 8) % 3), $sformatf("rotate%0d", i));
    end
    step(3'b000, 2'd3, "rotate_release");

    // A lone m0 keeps the bus for 20 cycles. Its saturated counter then makes
    // a newly arriving m1 preempt at once.
    for (int i = 0; i < 20; i++) begin
      step(3'b001, 2'd0, $sformatf("solo%0d", i));
    end
    step(3'b011, 2'd1, "late_preempt");
    step(3'b000, 2'd3, "late_release");

    // Asynchronous reset in the middle of a G1 grant.
    step(3'b010, 2'd1, "pre_reset_g1");
    #2;
    reset_n = 1'b0;
    #1;
    check_owner("async_reset_drop", 2'd3);
    {m2_req, m1_req, m0_req} = 3'b101;
    @(posedge clk);
    #1;
    check_owner("req_in_reset", 2'd3);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    step(3'b101, 2'd0, "post_reset_m0");
    step(3'b100, 2'd2, "post_reset_m2");
    step(3'b000, 2'd3, "final_idle");

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
